dct2d_block_ctrl: RTL and testbench

- Sequences the 8x8 2D DCT datapath (dct2d) for a row-serial stream.
- Gathers 8 input rows of 8 N-bit samples into a block buffer and presents the full 64-sample block to dct2d.
- Waits the datapath's fixed latency, captures the transformed block, then streams it out row by row under a valid/ready handshake.
- Sits between the pixel row source and the downstream quantiser / approximate-adder evaluation sink.

---
 rtl/dct_pkg.sv | 19 +
 rtl/dct2d_block_ctrl_if.sv | 38 +++
 rtl/dct_row_buffer.sv | 42 ++++
 rtl/dct2d_block_ctrl.sv | 125 ++++++++++++
 tb/tb_dct2d_block_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared types and helpers for the 8x8 DCT block controller.
// Holds the controller state enum, block geometry and the row packing helper.
package dct_pkg;

    localparam int DCT_DIM   = 8;
    localparam int DCT_ELEMS = 64;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bit offset of row r inside a packed block; row 0 sits in the MSBs.
    function automatic int row_offset(input int r, input int n);
        return (DCT_DIM - 1 - r) * DCT_DIM * n;
    endfunction

endpackage

// File: rtl/dct2d_block_ctrl_if.sv
// Row-stream handshake bundle for the DCT block controller.
// Carries the input row stream (valid/ready/row) and the output row stream
// (valid/ready/row/index). slave = controller side, master = source/sink side.
interface dct2d_block_ctrl_if
    import dct_pkg::*;
#(
    parameter int N = 16
);

    logic                   in_valid;
    logic                   in_ready;
    logic [DCT_DIM*N-1:0]   in_row;
    logic                   out_valid;
    logic                   out_ready;
    logic [DCT_DIM*N-1:0]   out_row;
    logic [2:0]             out_row_idx;

    modport slave (
        input  in_valid,
        input  in_row,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_row,
        output out_row_idx
    );

    modport master (
        output in_valid,
        output in_row,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_row,
        input  out_row_idx
    );

endinterface

// File: rtl/dct_row_buffer.sv
// 8-entry x 8N register file: single-row write by index or whole-block load,
// full 64N packed read (row 0 in MSBs). Ports: clk, rst_n (sync, active low),
// we/waddr/wdata row write, ld/ld_data block load (wins over we), rdata block read.
module dct_row_buffer
    import dct_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [2:0]               waddr,
    input  logic [DCT_DIM*N-1:0]     wdata,
    input  logic                     ld,
    input  logic [DCT_ELEMS*N-1:0]   ld_data,
    output logic [DCT_ELEMS*N-1:0]   rdata
);

    logic [DCT_DIM*N-1:0] mem [DCT_DIM];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DCT_DIM; i++) begin
                mem[i] <= '0;
            end
        end else if (ld) begin
            for (int i = 0; i < DCT_DIM; i++) begin
                mem[i] <= ld_data[row_offset(i, N) +: DCT_DIM*N];
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DCT_DIM; i++) begin
            rdata[row_offset(i, N) +: DCT_DIM*N] = mem[i];
        end
    end

endmodule

// File: rtl/dct2d_block_ctrl.sv
// Block sequencer for the 8x8 2D DCT: gathers 8 rows, holds the block for the
// datapath latency, captures the result and streams it out row by row.
// Ports: clk, rst_n (sync, active low), row_if (in/out row handshakes),
// dct_data_in/dct_data_out (packed blocks, row 0 in MSBs), busy, blk_cnt.
module dct2d_block_ctrl
    import dct_pkg::*;
#(
    parameter int N       = 16,
    parameter int DCT_LAT = 2,
    parameter int LAT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dct2d_block_ctrl_if.slave        row_if,
    output logic [DCT_ELEMS*N-1:0]   dct_data_in,
    input  logic [DCT_ELEMS*N-1:0]   dct_data_out,
    output logic                     busy,
    output logic [15:0]              blk_cnt
);

    state_t               state_q, state_d;
    logic [2:0]           row_q, row_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [15:0]          blk_q, blk_d;
    logic                 ov_q, ov_d;
    logic                 buf_we;
    logic                 res_ld;
    logic                 out_hs;
    logic [DCT_ELEMS*N-1:0] res_rd;

    dct_row_buffer #(.N(N)) u_blk_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (buf_we),
        .waddr   (row_q),
        .wdata   (row_if.in_row),
        .ld      (1'b0),
        .ld_data ('0),
        .rdata   (dct_data_in)
    );

    dct_row_buffer #(.N(N)) u_res_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (1'b0),
        .waddr   (3'd0),
        .wdata   ('0),
        .ld      (res_ld),
        .ld_data (dct_data_out),
        .rdata   (res_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            row_q   <= '0;
            lat_q   <= '0;
            blk_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            lat_q   <= lat_d;
            blk_q   <= blk_d;
            ov_q    <= ov_d;
        end
    end

    assign out_hs = ov_q && row_if.out_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        lat_d   = lat_q;
        blk_d   = blk_q;
        ov_d    = 1'b0;
        buf_we  = 1'b0;
        res_ld  = 1'b0;
        unique case (state_q)
            FILL: begin
                if (row_if.in_valid) begin
                    buf_we = 1'b1;
                    row_d  = row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        row_d   = '0;
                        lat_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_W'(DCT_LAT)) begin
                    res_ld  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // out_valid is a register: it rises one cycle into DRAIN and
                // drops in the same edge that retires row 7.
                ov_d = 1'b1;
                if (out_hs) begin
                    row_d = row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        row_d   = '0;
                        blk_d   = blk_q + 16'd1;
                        ov_d    = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign row_if.in_ready    = (state_q == FILL);
    assign row_if.out_valid   = ov_q;
    assign row_if.out_row     = res_rd[row_offset(int'(row_q), N) +: DCT_DIM*N];
    assign row_if.out_row_idx = (state_q == DRAIN) ? row_q : 3'd0;
    assign busy               = (state_q != FILL);
    assign blk_cnt            = blk_q;

endmodule

// File: tb/tb_dct2d_block_ctrl.sv
// Directed bench for dct2d_block_ctrl at DCT_LAT = 2, 0 and 7.
// Each DUT drives an inline stub that delays its block and XORs samples with 00FF.
module tb_dct2d_block_ctrl;

    localparam int N = 16;
    localparam int W = 64 * N;
    localparam logic [W-1:0] XMASK = {64{16'h00FF}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]   sel = 2'd0;
    logic         in_valid = 1'b0;
    logic [127:0] in_row = '0;
    logic         out_ready = 1'b1;

    dct2d_block_ctrl_if #(.N(N)) if_a ();
    dct2d_block_ctrl_if #(.N(N)) if_b ();
    dct2d_block_ctrl_if #(.N(N)) if_c ();

    assign if_a.in_valid  = in_valid && (sel == 2'd0);
    assign if_b.in_valid  = in_valid && (sel == 2'd1);
    assign if_c.in_valid  = in_valid && (sel == 2'd2);
    assign if_a.in_row    = in_row;
    assign if_b.in_row    = in_row;
    assign if_c.in_row    = in_row;
    assign if_a.out_ready = out_ready && (sel == 2'd0);
    assign if_b.out_ready = out_ready && (sel == 2'd1);
    assign if_c.out_ready = out_ready && (sel == 2'd2);

    logic [W-1:0] din_a, din_b, din_c;
    logic [W-1:0] dout_a, dout_b, dout_c;
    logic         busy_a, busy_b, busy_c;
    logic [15:0]  blk_a, blk_b, blk_c;

    logic [W-1:0] p2 [2];
    logic [W-1:0] p7 [7];

    always @(posedge clk) begin
        p2[0] <= din_a ^ XMASK;
        p2[1] <= p2[0];
        p7[0] <= din_c ^ XMASK;
        for (int i = 1; i < 7; i++) p7[i] <= p7[i-1];
    end
    assign dout_a = p2[1];
    assign dout_b = din_b ^ XMASK;
    assign dout_c = p7[6];

    dct2d_block_ctrl #(.N(N), .DCT_LAT(2), .LAT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .row_if(if_a),
        .dct_data_in(din_a), .dct_data_out(dout_a),
        .busy(busy_a), .blk_cnt(blk_a)
    );
    dct2d_block_ctrl #(.N(N), .DCT_LAT(0), .LAT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .row_if(if_b),
        .dct_data_in(din_b), .dct_data_out(dout_b),
        .busy(busy_b), .blk_cnt(blk_b)
    );
    dct2d_block_ctrl #(.N(N), .DCT_LAT(7), .LAT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .row_if(if_c),
        .dct_data_in(din_c), .dct_data_out(dout_c),
        .busy(busy_c), .blk_cnt(blk_c)
    );

    logic         ir_m, ov_m, busy_m;
    logic [127:0] orow_m;
    logic [2:0]   idx_m;
    logic [15:0]  blk_m;

    always_comb begin
        ir_m = if_a.in_ready; ov_m = if_a.out_valid;
        orow_m = if_a.out_row; idx_m = if_a.out_row_idx;
        busy_m = busy_a; blk_m = blk_a;
        case (sel)
            2'd1: begin
                ir_m = if_b.in_ready; ov_m = if_b.out_valid;
                orow_m = if_b.out_row; idx_m = if_b.out_row_idx;
                busy_m = busy_b; blk_m = blk_b;
            end
            2'd2: begin
                ir_m = if_c.in_ready; ov_m = if_c.out_valid;
                orow_m = if_c.out_row; idx_m = if_c.out_row_idx;
                busy_m = busy_c; blk_m = blk_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_row(input int r, input logic [15:0] base);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = base + 16'(r * 256 + k);
        return v;
    endfunction

    int acc_cyc = 0;

    task automatic send_block(input logic [15:0] base, input bit gap);
        for (int r = 0; r < 8; r++) begin
            int n = 0;
            if (gap && r > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_row   = mk_row(r, base);
            while (!ir_m && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("in_ready_timeout", 0, 1);
            @(negedge clk);
        end
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat, input string tag);
        int  n = 0;
        bit  ir_low = 1'b1;
        while (!ov_m && n < 50) begin
            if (ir_m) ir_low = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(exp_lat));
        chk({tag, "_ready_low"}, 128'(ir_low), 1);
        chk({tag, "_busy"}, 128'(busy_m), 1);
    endtask

    task automatic recv_block(input logic [15:0] base, input int stall_row,
                              input int stall_len, input int nrows,
                              input logic [15:0] blk0, input string tag);
        for (int r = 0; r < nrows; r++) begin
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    chk({tag, "_stall_valid"}, 128'(ov_m), 1);
                    chk({tag, "_stall_idx"}, 128'(idx_m), 128'(r));
                    chk({tag, "_stall_row"}, orow_m, mk_row(r, base) ^ {8{16'h00FF}});
                    chk({tag, "_stall_blk"}, 128'(blk_m), 128'(blk0));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            chk({tag, "_valid"}, 128'(ov_m), 1);
            chk({tag, "_idx"}, 128'(idx_m), 128'(r));
            chk({tag, "_row"}, orow_m, mk_row(r, base) ^ {8{16'h00FF}});
            chk({tag, "_ready_low"}, 128'(ir_m), 0);
            if (r == nrows - 1) begin
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_in_ready", 128'(ir_m), 1);
        chk("rst_out_valid", 128'(ov_m), 0);
        chk("rst_busy", 128'(busy_m), 0);
        chk("rst_blk", 128'(blk_m), 0);
        chk("rst_idx", 128'(idx_m), 0);
        chk("rst_dct_in", din_a[127:0], 0);

        // Basic block, DCT_LAT = 2.
        send_block(16'h0000, 1'b0);
        wait_out(4, "basic");
        recv_block(16'h0000, -1, 0, 8, 16'd0, "basic");
        chk("basic_blk", 128'(blk_m), 1);
        chk("basic_ready_back", 128'(ir_m), 1);
        chk("basic_valid_drop", 128'(ov_m), 0);

        // Gapped input.
        send_block(16'h0000, 1'b1);
        wait_out(4, "gap");
        recv_block(16'h0000, -1, 0, 8, 16'd1, "gap");
        chk("gap_blk", 128'(blk_m), 2);
        chk("gap_ready_back", 128'(ir_m), 1);

        // Backpressure on row 3.
        send_block(16'h3000, 1'b0);
        wait_out(4, "bp");
        recv_block(16'h3000, 3, 5, 8, 16'd2, "bp");
        chk("bp_blk", 128'(blk_m), 3);

        // Reset during DRAIN row 4.
        send_block(16'h5000, 1'b0);
        wait_out(4, "mid");
        recv_block(16'h5000, -1, 0, 4, 16'd3, "mid");
        chk("mid_idx_before_rst", 128'(idx_m), 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 128'(ov_m), 0);
        chk("mid_rst_ready", 128'(ir_m), 1);
        chk("mid_rst_blk", 128'(blk_m), 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_quiet", 128'(ov_m), 0);
        send_block(16'h6000, 1'b0);
        wait_out(4, "post");
        recv_block(16'h6000, -1, 0, 8, 16'd0, "post");
        chk("post_blk", 128'(blk_m), 1);

        // DCT_LAT = 0, two blocks.
        sel = 2'd1;
        @(negedge clk);
        send_block(16'h1000, 1'b0);
        wait_out(2, "l0a");
        recv_block(16'h1000, -1, 0, 8, 16'd0, "l0a");
        send_block(16'h2000, 1'b0);
        wait_out(2, "l0b");
        recv_block(16'h2000, -1, 0, 8, 16'd1, "l0b");
        chk("l0_blk", 128'(blk_m), 2);

        // DCT_LAT = 7, two blocks.
        sel = 2'd2;
        @(negedge clk);
        send_block(16'h4000, 1'b0);
        wait_out(9, "l7a");
        recv_block(16'h4000, -1, 0, 8, 16'd0, "l7a");
        send_block(16'h7000, 1'b0);
        wait_out(9, "l7b");
        recv_block(16'h7000, -1, 0, 8, 16'd1, "l7b");
        chk("l7_blk", 128'(blk_m), 2);

        // Block counter wrap.
        sel = 2'd0;
        @(negedge clk);
        force u_a.blk_q = 16'hFFFF;
        @(negedge clk);
        release u_a.blk_q;
        @(negedge clk);
        chk("wrap_pre", 128'(blk_m), 16'hFFFF);
        send_block(16'h0800, 1'b0);
        wait_out(4, "wrap");
        recv_block(16'h0800, -1, 0, 8, 16'hFFFF, "wrap");
        chk("wrap_blk", 128'(blk_m), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
